// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types, key map and row helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Indexed [row][col]; column 0 is the one driven by col_n = 4'b1110.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest-index low row wins.
  function automatic logic [1:0] row_index(input logic [3:0] row_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [3:0] row_n);
    logic [3:0] low;
    low = ~row_n;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, asserted on the wrap cycle.
module scan_tick_gen #(
  parameter int DIV = 24000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with press/release debounce and a two-digit history.
// Define KEYPAD_GHOST_REJECT_EN to reject multi-row presses in one column.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 24000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          tick;
  logic [3:0]    row_meta_q, row_sync_q;
  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;
  logic          ambiguous;
  logic          row_low;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
`ifdef KEYPAD_GHOST_REJECT_EN
    ambiguous   = multi_low(row_sync_q);
`else
    ambiguous   = 1'b0;
`endif
    row_low     = !row_sync_q[row_q];

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_sync_q != 4'hF && !ambiguous) begin
            row_d   = row_index(row_sync_q);
            cnt_d   = '0;
            state_d = DB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DB_PRESS: begin
          if (ambiguous || !row_low) begin
            cnt_d   = '0;
            state_d = SCAN;
          end else if (cnt_q == DB_LAST) begin
            cnt_d       = '0;
            state_d     = PRESSED;
            key_code_d  = KEYMAP[row_q][col_q];
            digit_old_d = digit_new_q;
            digit_new_d = KEYMAP[row_q][col_q];
            key_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!row_low) begin
            cnt_d   = '0;
            state_d = DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (row_low) begin
            cnt_d   = '0;
            state_d = PRESSED;
          end else if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    key_held_d = (state_d == PRESSED) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      row_meta_q  <= row_n;
      row_sync_q  <= row_meta_q;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a small switch-matrix model of the keypad.
module tb_keypad_scan_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic [3:0] keys [4];
  int checks = 0;
  int passed = 0;
  int strobes = 0;
  int vhigh = 0;
  logic prev_valid = 1'b0;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r] & ~col_n);
  end

  always @(negedge clk) begin
    vhigh      <= vhigh + (key_valid ? 1 : 0);
    strobes    <= strobes + ((key_valid && !prev_valid) ? 1 : 0);
    prev_valid <= key_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_keys;
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    clear_keys();
    wait_clk(5);
    checks++; if (col_n !== 4'b1110) $display("FAIL reset_col_n: got %b want 1110", col_n); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL reset_key_code: got %h want 0", key_code); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b want 0", key_held); else passed++;
    checks++; if (digit_new !== 4'h0) $display("FAIL reset_digit_new: got %h want 0", digit_new); else passed++;
    checks++; if (digit_old !== 4'h0) $display("FAIL reset_digit_old: got %h want 0", digit_old); else passed++;
    reset = 1'b0;
    n = 0;
    while (col_n == 4'b1110 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n !== 4) $display("FAIL first_rotate_cycles: got %0d want 4", n); else passed++;
    checks++; if (col_n !== 4'b1101) $display("FAIL first_rotate_col: got %b want 1101", col_n); else passed++;
    n = 0;
    while (col_n == 4'b1101 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n !== 4) $display("FAIL second_rotate_cycles: got %0d want 4", n); else passed++;
    checks++; if (col_n !== 4'b1011) $display("FAIL second_rotate_col: got %b want 1011", col_n); else passed++;
  endtask

  task automatic test_single_press;
    int s0;
    s0 = strobes;
    keys[1][2] = 1'b1;
    wait_clk(60);
    checks++; if (strobes - s0 !== 1) $display("FAIL single_strobes: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h6) $display("FAIL single_code: got %h want 6", key_code); else passed++;
    checks++; if (digit_new !== 4'h6) $display("FAIL single_digit_new: got %h want 6", digit_new); else passed++;
    checks++; if (digit_old !== 4'h0) $display("FAIL single_digit_old: got %h want 0", digit_old); else passed++;
    checks++; if (key_held !== 1'b1) $display("FAIL single_held: got %b want 1", key_held); else passed++;
    keys[1][2] = 1'b0;
    wait_clk(40);
    checks++; if (key_held !== 1'b0) $display("FAIL single_released: got %b want 0", key_held); else passed++;
    checks++; if (strobes - s0 !== 1) $display("FAIL single_no_repeat: got %0d want 1", strobes - s0); else passed++;
  endtask

  task automatic test_two_keys;
    int s0;
    s0 = strobes;
    keys[1][1] = 1'b1;
    wait_clk(60);
    keys[1][1] = 1'b0;
    wait_clk(40);
    keys[2][2] = 1'b1;
    wait_clk(60);
    keys[2][2] = 1'b0;
    wait_clk(40);
    checks++; if (strobes - s0 !== 2) $display("FAIL two_strobes: got %0d want 2", strobes - s0); else passed++;
    checks++; if (digit_old !== 4'h5) $display("FAIL two_digit_old: got %h want 5", digit_old); else passed++;
    checks++; if (digit_new !== 4'h9) $display("FAIL two_digit_new: got %h want 9", digit_new); else passed++;
    checks++; if (key_code !== 4'h9) $display("FAIL two_code: got %h want 9", key_code); else passed++;
  endtask

  task automatic test_bounce;
    int s0;
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      keys[0][0] = 1'b1; wait_clk(4);
      keys[0][0] = 1'b0; wait_clk(4);
    end
    keys[0][0] = 1'b1;
    wait_clk(60);
    checks++; if (strobes - s0 !== 1) $display("FAIL bounce_press_strobes: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h1) $display("FAIL bounce_code: got %h want 1", key_code); else passed++;
    for (int i = 0; i < 3; i++) begin
      keys[0][0] = 1'b0; wait_clk(4);
      keys[0][0] = 1'b1; wait_clk(4);
    end
    checks++; if (key_held !== 1'b1) $display("FAIL bounce_release_held: got %b want 1", key_held); else passed++;
    keys[0][0] = 1'b0;
    wait_clk(8);
    checks++; if (key_held !== 1'b1) $display("FAIL bounce_release_early: got %b want 1", key_held); else passed++;
    wait_clk(40);
    checks++; if (key_held !== 1'b0) $display("FAIL bounce_release_final: got %b want 0", key_held); else passed++;
    checks++; if (strobes - s0 !== 1) $display("FAIL bounce_total_strobes: got %0d want 1", strobes - s0); else passed++;
  endtask

  task automatic test_held_other_key;
    int s0;
    s0 = strobes;
    keys[3][1] = 1'b1;
    wait_clk(60);
    checks++; if (strobes - s0 !== 1) $display("FAIL held_first_strobe: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL held_first_code: got %h want 0", key_code); else passed++;
    keys[0][3] = 1'b1;
    wait_clk(60);
    checks++; if (strobes - s0 !== 1) $display("FAIL held_second_strobe: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL held_code_kept: got %h want 0", key_code); else passed++;
    checks++; if (col_n !== 4'b1101) $display("FAIL held_col_frozen: got %b want 1101", col_n); else passed++;
    keys[3][1] = 1'b0;
    keys[0][3] = 1'b0;
    wait_clk(40);
  endtask

  task automatic test_multi_row;
    int s0;
    s0 = strobes;
    keys[2][0] = 1'b1;
    keys[3][0] = 1'b1;
    wait_clk(60);
`ifdef KEYPAD_GHOST_REJECT_EN
    checks++; if (strobes - s0 !== 0) $display("FAIL ghost_strobes: got %0d want 0", strobes - s0); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL ghost_held: got %b want 0", key_held); else passed++;
`else
    checks++; if (strobes - s0 !== 1) $display("FAIL multi_strobes: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h7) $display("FAIL multi_code: got %h want 7", key_code); else passed++;
`endif
    keys[2][0] = 1'b0;
    keys[3][0] = 1'b0;
    wait_clk(40);
  endtask

  task automatic test_reset_mid_press;
    int s0;
    reset = 1'b1;
    wait_clk(2);
    keys[1][0] = 1'b1;
    reset = 1'b0;
    // Detection tick at edge 4; the strobe would land at edge 16.
    wait_clk(8);
    s0 = strobes;
    checks++; if (key_held !== 1'b0) $display("FAIL mid_in_debounce: got %b want 0", key_held); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (col_n !== 4'b1110) $display("FAIL mid_col_n: got %b want 1110", col_n); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL mid_key_code: got %h want 0", key_code); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL mid_key_valid: got %b want 0", key_valid); else passed++;
    checks++; if (digit_new !== 4'h0) $display("FAIL mid_digit_new: got %h want 0", digit_new); else passed++;
    checks++; if (digit_old !== 4'h0) $display("FAIL mid_digit_old: got %h want 0", digit_old); else passed++;
    wait_clk(10);
    checks++; if (strobes - s0 !== 0) $display("FAIL mid_no_strobe: got %0d want 0", strobes - s0); else passed++;
    reset = 1'b0;
    wait_clk(40);
    checks++; if (strobes - s0 !== 1) $display("FAIL redetect_strobe: got %0d want 1", strobes - s0); else passed++;
    checks++; if (key_code !== 4'h4) $display("FAIL redetect_code: got %h want 4", key_code); else passed++;
    checks++; if (digit_new !== 4'h4) $display("FAIL redetect_digit_new: got %h want 4", digit_new); else passed++;
    keys[1][0] = 1'b0;
    wait_clk(40);
  endtask

  initial begin
    reset = 1'b1;
    clear_keys();
    test_reset();
    test_single_press();
    test_two_keys();
    test_bounce();
    test_held_other_key();
    test_multi_row();
    test_reset_mid_press();
    wait_clk(2);
    checks++; if (vhigh !== strobes) $display("FAIL strobe_width: got %0d high cycles for %0d strobes", vhigh, strobes); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
